// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller.
package seg_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int IDX_W      = 2;

   localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'b1111;
   localparam logic [6:0]            SEG_OFF = 7'b1111111;

   // Active-low {g,f,e,d,c,b,a} patterns, entry 15 leftmost.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   typedef struct packed {
      logic [NUM_DIGITS*4-1:0] value;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
   } disp_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with frame-synchronous load.
// Optional per-digit blinking is enabled by defining SEG_BLINK_EN.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned GUARD_CYC   = 2
`ifdef SEG_BLINK_EN
   ,
   parameter int unsigned BLINK_FRAMES = 64
`endif
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [NUM_DIGITS*4-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEG_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink,
`endif
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    pending,
   output logic                    frame_tick
);

   localparam int unsigned DIV_W = $clog2(REFRESH_DIV);

   logic [DIV_W-1:0]      div_reg, div_next;
   logic [IDX_W-1:0]      idx_reg, idx_next;
   disp_t                 shadow_reg, shadow_next;
   disp_t                 active_reg, active_next;
   logic                  pending_reg, pending_next;
   logic [NUM_DIGITS-1:0] an_reg, an_next;
   logic [6:0]            seg_reg, seg_next;
   logic                  dp_reg, dp_next;
   logic                  frame_tick_reg, frame_tick_next;

   logic                  wrap, boundary, guard;
   disp_t                 load_data;
   logic [NUM_DIGITS-1:0] blank_eff;
   logic [NUM_DIGITS-1:0] an_sel;
   logic [3:0]            nib_arr [NUM_DIGITS];
   logic [3:0]            nibble;
   logic [6:0]            seg_dec;

   assign wrap      = (div_reg == DIV_W'(REFRESH_DIV - 1));
   assign boundary  = wrap && (idx_reg == IDX_W'(NUM_DIGITS - 1));
   assign guard     = (div_reg < DIV_W'(GUARD_CYC));
   assign load_data = '{value: value, dp: dp_in, blank: blank_in};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign an_sel[gi]  = (idx_reg != IDX_W'(gi));
         assign nib_arr[gi] = active_reg.value[gi*4 +: 4];
      end
   endgenerate

   assign nibble = nib_arr[idx_reg];

   seg_hex_decode u_hex_decode (
      .nibble (nibble),
      .seg    (seg_dec)
   );

`ifdef SEG_BLINK_EN
   localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [BLK_W-1:0] blk_cnt_reg, blk_cnt_next;
   logic             phase_reg, phase_next;

   always_comb begin
      blk_cnt_next = blk_cnt_reg;
      phase_next   = phase_reg;
      if (boundary) begin
         if (blk_cnt_reg == BLK_W'(BLINK_FRAMES - 1)) begin
            blk_cnt_next = '0;
            phase_next   = ~phase_reg;
         end else begin
            blk_cnt_next = blk_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt_reg <= '0;
         phase_reg   <= 1'b0;
      end else begin
         blk_cnt_reg <= blk_cnt_next;
         phase_reg   <= phase_next;
      end
   end

   // Blink is live: it bypasses the load shadow on purpose.
   assign blank_eff = active_reg.blank | (blink & {NUM_DIGITS{phase_reg}});
`else
   assign blank_eff = active_reg.blank;
`endif

   always_comb begin
      div_next = wrap ? '0 : div_reg + 1'b1;
      idx_next = wrap ? idx_reg + 1'b1 : idx_reg;
   end

   // A load landing on the boundary commits directly; otherwise it waits in the shadow.
   always_comb begin
      shadow_next  = shadow_reg;
      active_next  = active_reg;
      pending_next = pending_reg;
      if (boundary) begin
         if (load) begin
            active_next = load_data;
         end else if (pending_reg) begin
            active_next = shadow_reg;
         end
         pending_next = 1'b0;
      end else if (load) begin
         shadow_next  = load_data;
         pending_next = 1'b1;
      end
   end

   always_comb begin
      an_next         = AN_OFF;
      seg_next        = SEG_OFF;
      dp_next         = 1'b1;
      frame_tick_next = boundary;
      if (!guard && !blank_eff[idx_reg]) begin
         an_next  = an_sel;
         seg_next = seg_dec;
         dp_next  = ~active_reg.dp[idx_reg];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_reg        <= '0;
         idx_reg        <= '0;
         shadow_reg     <= '0;
         active_reg     <= '0;
         pending_reg    <= 1'b0;
         an_reg         <= AN_OFF;
         seg_reg        <= SEG_OFF;
         dp_reg         <= 1'b1;
         frame_tick_reg <= 1'b0;
      end else begin
         div_reg        <= div_next;
         idx_reg        <= idx_next;
         shadow_reg     <= shadow_next;
         active_reg     <= active_next;
         pending_reg    <= pending_next;
         an_reg         <= an_next;
         seg_reg        <= seg_next;
         dp_reg         <= dp_next;
         frame_tick_reg <= frame_tick_next;
      end
   end

   assign an         = an_reg;
   assign seg        = seg_reg;
   assign dp         = dp_reg;
   assign pending    = pending_reg;
   assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at REFRESH_DIV=8, GUARD_CYC=2 (blink steps with SEG_BLINK_EN).
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic [3:0]  blink = '0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        pending;
   logic        frame_tick;

   int n_tests = 0;
   int n_fail  = 0;
   int e       = 0;   // posedges since the latest reset release

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .REFRESH_DIV (8),
      .GUARD_CYC   (2)
`ifdef SEG_BLINK_EN
      ,
      .BLINK_FRAMES(2)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .value      (value),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
`ifdef SEG_BLINK_EN
      .blink      (blink),
`endif
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .pending    (pending),
      .frame_tick (frame_tick)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s at edge %0d: observed %h expected %h", tag, e, obs, exp);
      end
      $display("[TB] edge %0d %s observed %h expected %h", e, tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
      e += n;
   endtask

   task automatic goto(input int t);
      if (t > e) tick(t - e);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value    = v;
      dp_in    = d;
      blank_in = b;
      load     = 1'b1;
      tick(1);
      load     = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_seg", 16'(seg), 16'h7F);
      chk("rst_dp", 16'(dp), 16'h1);
      chk("rst_pending", 16'(pending), 16'h0);
      chk("rst_ftick", 16'(frame_tick), 16'h0);

      rst_n = 1'b1;
      e = 0;
      goto(2);  chk("guard_an", 16'(an), 16'hF);
      goto(3);  chk("first_an", 16'(an), 16'hE);
      chk("first_seg0", 16'(seg), 16'h40);

      // Load 1234 mid-frame: pending now, display unchanged until the boundary.
      do_load(16'h1234, 4'h0, 4'h0);
      chk("pend_rise", 16'(pending), 16'h1);
      chk("no_tear_seg", 16'(seg), 16'h40);
      goto(31); chk("pend_hold", 16'(pending), 16'h1);
      chk("ftick_pre", 16'(frame_tick), 16'h0);
      goto(32); chk("pend_fall", 16'(pending), 16'h0);
      chk("ftick_b1", 16'(frame_tick), 16'h1);
      goto(33); chk("ftick_post", 16'(frame_tick), 16'h0);
      chk("slot0_guard_a", 16'(an), 16'hF);
      goto(34); chk("slot0_guard_b", 16'(an), 16'hF);
      goto(35); chk("d0_an", 16'(an), 16'hE);
      chk("d0_seg4", 16'(seg), 16'h19);
      chk("d0_dp", 16'(dp), 16'h1);
      goto(41); chk("slot1_guard", 16'(an), 16'hF);
      goto(43); chk("d1_an", 16'(an), 16'hD);
      chk("d1_seg3", 16'(seg), 16'h30);
      goto(51); chk("d2_an", 16'(an), 16'hB);
      chk("d2_seg2", 16'(seg), 16'h24);
      goto(59); chk("d3_an", 16'(an), 16'h7);
      chk("d3_seg1", 16'(seg), 16'h79);
      goto(64); chk("ftick_b2", 16'(frame_tick), 16'h1);

      // Two loads in one frame: last wins at the boundary.
      goto(65); do_load(16'hAAAA, 4'h0, 4'h0);
      chk("pend_a", 16'(pending), 16'h1);
      goto(69); do_load(16'h5555, 4'h0, 4'h0);
      goto(75); chk("mid_d1_an", 16'(an), 16'hD);
      chk("mid_d1_seg3", 16'(seg), 16'h30);
      goto(95); chk("pend_5_hold", 16'(pending), 16'h1);
      goto(96); chk("pend_5_fall", 16'(pending), 16'h0);
      chk("ftick_b3", 16'(frame_tick), 16'h1);
      goto(99);  chk("five_d0", 16'({an, seg}), 16'({4'hE, 7'h12}));
      goto(107); chk("five_d1", 16'({an, seg}), 16'({4'hD, 7'h12}));
      goto(123); chk("five_d3", 16'({an, seg}), 16'({4'h7, 7'h12}));
      goto(127); chk("ftick_gap", 16'(frame_tick), 16'h0);

      // Load landing exactly on the boundary edge goes straight to active.
      do_load(16'h8888, 4'h0, 4'h0);
      chk("bnd_pend", 16'(pending), 16'h0);
      chk("ftick_b4", 16'(frame_tick), 16'h1);
      goto(131); chk("eight_d0", 16'({an, seg}), 16'({4'hE, 7'h00}));
      goto(135); chk("bnd_pend_later", 16'(pending), 16'h0);
      goto(139); chk("eight_d1", 16'({an, seg}), 16'({4'hD, 7'h00}));

      // Blank digit 3, decimal point on digit 0.
      do_load(16'h1234, 4'b0001, 4'b1000);
      goto(163); chk("bl_d0", 16'({an, seg}), 16'({4'hE, 7'h19}));
      chk("bl_d0_dp", 16'(dp), 16'h0);
      goto(171); chk("bl_d1_an", 16'(an), 16'hD);
      chk("bl_d1_dp", 16'(dp), 16'h1);
      goto(179); chk("bl_d2_dp", 16'(dp), 16'h1);
      goto(187); chk("bl_d3_an", 16'(an), 16'hF);
      chk("bl_d3_dp", 16'(dp), 16'h1);
      goto(190); chk("bl_d3_an_late", 16'(an), 16'hF);

      // Asynchronous reset in the middle of digit 2's slot with a load pending.
      goto(209); do_load(16'hFFFF, 4'h0, 4'h0);
      goto(212); chk("pre_rst_an", 16'(an), 16'hB);
      chk("pre_rst_seg", 16'(seg), 16'h24);
      chk("pre_rst_pend", 16'(pending), 16'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_an", 16'(an), 16'hF);
      chk("arst_seg", 16'(seg), 16'h7F);
      chk("arst_dp", 16'(dp), 16'h1);
      chk("arst_pend", 16'(pending), 16'h0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      e = 0;
`ifdef SEG_BLINK_EN
      blink = 4'b0001;
`endif
      goto(2);  chk("re_guard", 16'(an), 16'hF);
      goto(3);  chk("re_d0", 16'({an, seg}), 16'({4'hE, 7'h40}));
      goto(32); chk("re_no_commit", 16'(pending), 16'h0);
      goto(35); chk("re_shadow_clr", 16'({an, seg}), 16'({4'hE, 7'h40}));

`ifdef SEG_BLINK_EN
      goto(67);  chk("blink_off_f2", 16'(an), 16'hF);
      goto(75);  chk("blink_d1_f2", 16'(an), 16'hD);
      goto(99);  chk("blink_off_f3", 16'(an), 16'hF);
      goto(131); chk("blink_on_f4", 16'(an), 16'hE);
`else
      goto(67);  chk("noblink_f2", 16'(an), 16'hE);
      goto(99);  chk("noblink_f3", 16'(an), 16'hE);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode 7-segment display shared by both players' scores. It owns the refresh timebase and selects one digit at a time through an active-low one-cold anode select. For each digit it drives the matching active-low segment pattern, with a guard gap between digits to prevent ghosting. A load handshake captures new display values tear-free: they become visible only at a frame boundary.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; must be at least 4.
- GUARD_CYC, 2: cycles at the start of each slot with all anodes off; must be at least 1 and less than REFRESH_DIV.
- BLINK_FRAMES, 64: frames per blink phase; only used with SEG_BLINK_EN.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- load  in  1  one-cycle strobe; captures value, dp_in and blank_in.
- value  in  16  four hex nibbles; [3:0] is digit 0 (rightmost).
- dp_in  in  4  decimal point enable per digit, active-high.
- blank_in  in  4  per-digit blank, active-high.
- blink  in  4  per-digit blink enable; present only with SEG_BLINK_EN.
- an  out  4  anode select, active-low one-cold (at most one bit 0).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- pending  out  1  a loaded value is waiting for the frame boundary.
- frame_tick  out  1  one-cycle pulse after each frame commit point.

## Operation
- Divider counts 0..REFRESH_DIV-1 and wraps.
- Digit index (2 bits) increments on divider wrap; 3 wraps to 0.
- Frame boundary: divider wrap while index is 3.
- Anode select for index 0/1/2/3 is 1110/1101/1011/0111.
- Guard region (divider < GUARD_CYC): an=1111, seg=1111111, dp=1.
- Outside the guard region:
  - If the active blank bit for the current index is set: an=1111.
  - Otherwise: an = one-cold select of the index, seg = hex decode of the active nibble, dp = ~active dp bit.
- Hex decode examples: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
- Load, no boundary in the same cycle: shadow ← inputs, pending ← 1. A later load before the boundary overwrites the shadow (last wins).
- Frame boundary with pending=1: active ← shadow, pending ← 0.
- Load coincident with a boundary: the inputs go directly to active and pending ← 0; any older shadow is discarded.
- Loads never change the digit currently being displayed mid-frame.

## Timing
- an, seg, dp and frame_tick are registered: they reflect divider/index state with one clock of latency.
- Slot length is REFRESH_DIV cycles; frame length is 4×REFRESH_DIV cycles.
- frame_tick is high for exactly the one cycle after each frame boundary, whether or not a commit occurred.
- pending rises the cycle after a load and falls the cycle after the commit.
- Reset (asynchronous, any time, including mid-slot or mid-frame) forces:
  - divider=0, index=0, shadow=0, active=0, pending=0, blink phase=0;
  - an=1111, seg=1111111, dp=1, frame_tick=0.
- After reset release, scanning starts at digit 0, guard region first. The first unblanked an (1110) appears at cycle GUARD_CYC+1.

## Configuration
- SEG_BLINK_EN defined:
  - adds the blink port and a blink phase register;
  - the phase toggles after every BLINK_FRAMES frame boundaries;
  - while phase=1, digits with their blink bit set are treated as blanked;
  - blink is sampled live, not through the load shadow.
- SEG_BLINK_EN undefined: no blink port, no phase logic; behaviour is otherwise identical.

## Structure
- Package seg_pkg holds:
  - NUM_DIGITS=4;
  - the 16-entry active-low hex segment constants;
  - the all-off constants AN_OFF=4'b1111 and SEG_OFF=7'b1111111.
- Sub-module seg_hex_decode: combinational 4-bit to 7-bit active-low segment decode, instantiated once on the muxed nibble.
- Top level holds the divider, index, guard compare, shadow/active registers and output registers.

## Test plan
Run with REFRESH_DIV=8 and GUARD_CYC=2.
- Reset, then load value=16'h1234, dp_in=0, blank_in=0 → after the first boundary, slots show an=1110 with seg=0011001 (4), then 1101/0110000 (3), 1011/0100100 (2), 0111/1111001 (1). an=1111 for 2 cycles at each slot start.
- Two loads within one frame (16'hAAAA, then 16'h5555) → the next frame shows only 5s; pending=1 until the boundary, then 0; frame_tick pulses once per 32 cycles.
- Load 16'h8888 on exactly the boundary cycle → the next frame shows 8s (seg=0000000); pending is never asserted.
- blank_in=4'b1000 with dp_in=4'b0001 → an never equals 0111; dp=0 only while an=1110.
- Assert rst_n low mid-slot with an=1011 → an=1111, seg=1111111 and pending=0 immediately (asynchronous); after release, the scan restarts at digit 0.
- With SEG_BLINK_EN, BLINK_FRAMES=2, blink=4'b0001 → digit 0 is visible for 2 frames and dark for 2 frames, alternating; the other digits are unaffected.
